booth_mul_seq: RTL and testbench

Iterative radix-4 Booth multiplier sequencer for the MUL unit. It time-multiplexes one Booth partial-product slice over successive multiplier digits, accumulating one partial product per cycle. Valid/ready on both sides, between the EXU issue logic and writeback. Supports 64-bit and 32-bit word (mulw) operation with selectable operand signedness.

---
 rtl/mul_pkg.sv | 49 ++++
 rtl/booth_mul_seq_if.sv | 35 +++
 rtl/booth_pp.sv | 37 +++
 rtl/booth_mul_seq.sv | 165 ++++++++++++++++
 tb/tb_booth_mul_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the iterative radix-4 Booth
//               multiplier: FSM states, signedness encodings, Booth digit
//               decode and per-mode iteration counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // {src1_signed, src2_signed}
    localparam logic [1:0] c_SIGN_SS = 2'b11;
    localparam logic [1:0] c_SIGN_SU = 2'b10;
    localparam logic [1:0] c_SIGN_UU = 2'b00;

    // Booth digits that select a doubled multiplicand
    localparam logic [2:0] c_DIG_P2 = 3'b011;
    localparam logic [2:0] c_DIG_M2 = 3'b100;

    // Digit count for word mode: 32 operand bits plus one extension digit
    localparam int c_ITER_WORD = 17;

    // Decoded Booth digit: select X, select 2X, negate
    typedef struct packed {
        logic one;
        logic two;
        logic neg;
    } booth_dec_t;

    function automatic booth_dec_t booth_decode(input logic [2:0] digit);
        booth_dec_t dec;
        dec.one = digit[0] ^ digit[1];
        dec.two = (digit == c_DIG_P2) | (digit == c_DIG_M2);
        // 3'b111 encodes zero; keeping neg low avoids a needless negate
        dec.neg = digit[2] & ~(digit[1] & digit[0]);
        return dec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mul_seq_if.sv
// ============================================================================
// Module      : booth_mul_seq_if
// Description : Request/result handshake bundle between the issue logic
//               (master) and the Booth multiplier sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface booth_mul_seq_if #(
    parameter int XLEN = 64
) ();
    logic            flush;
    logic            mul_valid;
    logic            mul_ready;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output flush, mul_valid, mulw, mul_signed, multiplicand, multiplier, out_ready,
        input  mul_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  flush, mul_valid, mulw, mul_signed, multiplicand, multiplier, out_ready,
        output mul_ready, out_valid, result_hi, result_lo
    );
endinterface

`default_nettype wire

// File: rtl/booth_pp.sv
// ============================================================================
// Module      : booth_pp
// Description : Radix-4 Booth partial-product slice. Decodes one 3-bit
//               multiplier window and produces 0, +/-X or +/-2X in two's
//               complement at full product width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_pp
    import mul_pkg::*;
#(
    parameter int PW = 128
) (
    input  wire logic [2:0]    i_digit,
    input  wire logic [PW-1:0] i_x,
    output logic      [PW-1:0] o_pp
);

    booth_dec_t          w_dec;
    logic     [PW-1:0]   w_mag;

    // Select magnitude from the decoded digit, then negate if required
    always_comb begin
        w_dec = booth_decode(i_digit);
        w_mag = '0;
        if (w_dec.one) begin
            w_mag = i_x;
        end else if (w_dec.two) begin
            w_mag = i_x << 1;
        end
        o_pp = w_dec.neg ? (~w_mag + PW'(1)) : w_mag;
    end

endmodule

`default_nettype wire

// File: rtl/booth_mul_seq.sv
// ============================================================================
// Module      : booth_mul_seq
// Description : Iterative radix-4 Booth multiplier sequencer. One partial
//               product is accumulated per cycle; supports XLEN and 32-bit
//               word (mulw) operation with selectable operand signedness.
//               Optional macro MUL_EARLY_TERM_EN: leave CALC as soon as all
//               remaining multiplier digits encode zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ITER_W = 6
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    booth_mul_seq_if.slave  bus
);

    localparam int               c_PW        = 2 * XLEN;
    localparam int               c_YW        = XLEN + 3;
    localparam logic [ITER_W-1:0] c_ITER_FULL = ITER_W'(XLEN / 2 + 1);
    localparam logic [ITER_W-1:0] c_ITER_W32  = ITER_W'(c_ITER_WORD);
    localparam logic [ITER_W-1:0] c_ITER_ONE  = ITER_W'(1);

    mul_state_e          r_state;
    mul_state_e          w_state_next;
    logic [c_PW-1:0]     r_x;
    logic [c_PW-1:0]     r_acc;
    logic [c_YW-1:0]     r_y;
    logic [ITER_W-1:0]   r_cnt;
    logic                r_mulw;
    logic [XLEN-1:0]     r_res_hi;
    logic [XLEN-1:0]     r_res_lo;

    logic [c_PW-1:0]     w_x_init;
    logic [c_YW-1:0]     w_y_init;
    logic [c_YW-1:0]     w_y_next;
    logic [c_PW-1:0]     w_pp;
    logic [c_PW-1:0]     w_acc_next;
    logic                w_accept;
    logic                w_calc_last;
    logic                w_src1_ext;
    logic                w_src2_ext;

    booth_pp #(
        .PW (c_PW)
    ) u_booth_pp (
        .i_digit (r_y[2:0]),
        .i_x     (r_x),
        .o_pp    (w_pp)
    );

    // Operand extension to the working widths for the selected mode
    always_comb begin
        if (bus.mulw) begin
            w_src1_ext = bus.mul_signed[1] & bus.multiplicand[31];
            w_src2_ext = bus.mul_signed[0] & bus.multiplier[31];
            w_x_init   = {{(c_PW - 32){w_src1_ext}}, bus.multiplicand[31:0]};
            w_y_init   = {{(c_YW - 33){w_src2_ext}}, bus.multiplier[31:0], 1'b0};
        end else begin
            w_src1_ext = bus.mul_signed[1] & bus.multiplicand[XLEN-1];
            w_src2_ext = bus.mul_signed[0] & bus.multiplier[XLEN-1];
            w_x_init   = {{XLEN{w_src1_ext}}, bus.multiplicand};
            w_y_init   = {{2{w_src2_ext}}, bus.multiplier, 1'b0};
        end
    end

    // Next accumulator, shifted multiplier and CALC exit condition
    always_comb begin
        w_acc_next = r_acc + w_pp;
        w_y_next   = {{2{r_y[c_YW-1]}}, r_y[c_YW-1:2]};
`ifdef MUL_EARLY_TERM_EN
        // Remaining window all-zero or all-one means every further digit is 0
        w_calc_last = (r_cnt == c_ITER_ONE) | (&w_y_next) | ~(|w_y_next);
`else
        w_calc_last = (r_cnt == c_ITER_ONE);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; flush overrides every transition
    always_comb begin
        w_state_next  = r_state;
        bus.mul_ready = 1'b0;
        bus.out_valid = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.mul_ready = ~bus.flush;
                w_accept      = bus.mul_valid & ~bus.flush;
                if (w_accept) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_calc_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (bus.flush) begin
            w_state_next = IDLE;
        end
    end

    // Datapath: load operands on accept, accumulate one digit per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mulw   <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else if (w_accept) begin
            r_x    <= w_x_init;
            r_y    <= w_y_init;
            r_acc  <= '0;
            r_cnt  <= bus.mulw ? c_ITER_W32 : c_ITER_FULL;
            r_mulw <= bus.mulw;
        end else if ((r_state == CALC) && !bus.flush) begin
            r_acc <= w_acc_next;
            r_x   <= r_x << 2;
            r_y   <= w_y_next;
            r_cnt <= r_cnt - c_ITER_ONE;
            if (w_calc_last) begin
                if (r_mulw) begin
                    r_res_hi <= '0;
                    r_res_lo <= {{(XLEN - 32){w_acc_next[31]}}, w_acc_next[31:0]};
                end else begin
                    r_res_hi <= w_acc_next[c_PW-1:XLEN];
                    r_res_lo <= w_acc_next[XLEN-1:0];
                end
            end
        end
    end

    assign bus.result_hi = r_res_hi;
    assign bus.result_lo = r_res_lo;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
// ============================================================================
// Module      : tb_booth_mul_seq
// Description : Scoreboard testbench for booth_mul_seq: directed corner
//               products, randomized operands, flush, back-pressure and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mul_seq;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   hold_ready;
    exp_t q[$];

    bit          prev_valid;
    bit          prev_hs;
    logic [63:0] saved_hi;
    logic [63:0] saved_lo;

    booth_mul_seq_if #(.XLEN(64)) bus ();

    booth_mul_seq #(
        .XLEN   (64),
        .ITER_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference product from plain wide arithmetic
    function automatic exp_t model(input bit w, input bit [1:0] sg,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        if (w) begin
            ea = sg[1] ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
            eb = sg[0] ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
            p  = ea * eb;
            e.hi = 64'd0;
            e.lo = {{32{p[31]}}, p[31:0]};
            e.lat = 18;
        end else begin
            ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
            eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
            p  = ea * eb;
            e.hi = p[127:64];
            e.lo = p[63:0];
            e.lat = 34;
        end
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic issue(input bit w, input bit [1:0] sg, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   waited;
        bit   ok;
        bus.mulw         = w;
        bus.mul_signed   = sg;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.mul_valid    = 1'b1;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (bus.mul_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            fail_now("accept_timeout");
            bus.mul_valid = 1'b0;
        end else begin
            e = model(w, sg, a, b);
            e.acc_cyc = cyc;
            q.push_back(e);
            @(posedge clk);
            #1;
            bus.mul_valid    = 1'b0;
            bus.multiplicand = {$urandom, $urandom};
            bus.multiplier   = {$urandom, $urandom};
            @(negedge clk);
            check("ready_low_busy", 64'(bus.mul_ready), 64'd0);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((q.size() != 0 || bus.out_valid) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) fail_now("drain_timeout");
    endtask

    // Back-pressure generator
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on result arrival, stability under back-pressure,
    // value comparison on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (bus.out_valid) begin
                check("ready_low_done", 64'(bus.mul_ready), 64'd0);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
`ifdef MUL_EARLY_TERM_EN
                        check("latency_max", 64'((cyc - q[0].acc_cyc) <= q[0].lat), 64'd1);
`else
                        check("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
`endif
                    end
                end else if (!prev_hs) begin
                    check("stable_hi", bus.result_hi, saved_hi);
                    check("stable_lo", bus.result_lo, saved_lo);
                end
                if (bus.out_ready && !bus.flush && q.size() != 0) begin
                    check("result_hi", bus.result_hi, q[0].hi);
                    check("result_lo", bus.result_lo, q[0].lo);
                    void'(q.pop_front());
                end
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid & bus.out_ready & ~bus.flush;
            saved_hi   = bus.result_hi;
            saved_lo   = bus.result_lo;
        end
    end

    initial begin
        logic [63:0] ones;
        bit   [1:0]  sg;
        int          waited;
        ones             = '1;
        n_checks         = 0;
        n_pass           = 0;
        cyc              = 0;
        hold_ready       = 1'b0;
        rst_n            = 1'b0;
        bus.flush        = 1'b0;
        bus.mul_valid    = 1'b0;
        bus.mulw         = 1'b0;
        bus.mul_signed   = 2'b00;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result_hi", bus.result_hi, 64'd0);
        check("rst_result_lo", bus.result_lo, 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mul_ready", 64'(bus.mul_ready), 64'd1);

        // Directed corner products
        @(posedge clk); #1;
        issue(1'b0, 2'b00, 64'd3, 64'd5);
        issue(1'b0, 2'b11, ones, ones);
        issue(1'b0, 2'b10, ones, ones);
        issue(1'b0, 2'b00, ones, ones);
        issue(1'b1, 2'b11, 64'h7FFF_FFFF, 64'd2);
        issue(1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        issue(1'b1, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF);

        // Randomized operands, modes and signedness
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       sg = 2'b11;
                1:       sg = 2'b10;
                default: sg = 2'b00;
            endcase
            issue(1'(($urandom_range(0, 2) == 0)), sg,
                  ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom});
        end

        // Flush during CALC drops the operation; next one completes normally
        drain();
        @(posedge clk); #1;
        issue(1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_ready_low", 64'(bus.mul_ready), 64'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_idle_ready", 64'(bus.mul_ready), 64'd1);
        @(posedge clk); #1;
        issue(1'b0, 2'b00, 64'd6, 64'd7);
        drain();

        // Request presented together with flush in IDLE is not accepted
        @(posedge clk); #1;
        bus.mul_valid = 1'b1;
        bus.flush     = 1'b1;
        @(negedge clk);
        check("flush_blocks_accept", 64'(bus.mul_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.mul_valid = 1'b0;
        bus.flush     = 1'b0;
        repeat (40) @(negedge clk);
        check("no_result_after_flush", 64'(bus.out_valid), 64'd0);

        // Back-pressure: result held for 5 cycles
        hold_ready = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0100);
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) fail_now("done_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        hold_ready = 1'b0;
        drain();

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        issue(1'b0, 2'b11, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_result_hi", bus.result_hi, 64'd0);
        check("arst_result_lo", bus.result_lo, 64'd0);
        check("arst_idle_ready", 64'(bus.mul_ready), 64'd1);
        void'(q.pop_back());
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b1, 2'b10, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_0003);
        drain();
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
